// File: rtl/present_cipher_core.sv
// present_cipher_core: iterative PRESENT block cipher, encrypt and decrypt, one round per clock.
// Decryption expands the raw master key on chip (KEYGEN phase) before running rounds backwards.
// Optional feature macro: PRESENT_KEY_CACHE_EN keeps the last decrypt key schedule so a repeated
// decrypt under the same master key skips the key expansion phase.
module present_cipher_core #(
   parameter int KEY_WIDTH = 80
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic [63:0]          in_data,
   input  logic [KEY_WIDTH-1:0] in_key,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [63:0]          out_data,
   output logic                 busy,
   output logic [4:0]           round
);

   generate
      if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
         $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
      end
   endgenerate

   // The round counter is folded into the key register at a width-dependent position
   localparam int RC_LSB = (KEY_WIDTH == 128) ? 62 : 15;

   typedef enum logic [1:0] {IDLE, KEYGEN, ROUND, DONE} state_e;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
      return y;
   endfunction

   function automatic logic [63:0] s_layer_inv(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox_inv(x[4*i +: 4]);
      return y;
   endfunction

   // Bit i moves to position 16*i mod 63 (bit 63 stays put)
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[(i % 4) * 16 + i / 4] = x[i];
      return y;
   endfunction

   function automatic logic [63:0] p_layer_inv(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[i] = x[(i % 4) * 16 + i / 4];
      return y;
   endfunction

   // Forward key schedule step: rotate left 61, S-box top nibble(s), fold in round counter
   function automatic logic [KEY_WIDTH-1:0] key_fwd(input logic [KEY_WIDTH-1:0] k,
                                                    input logic [4:0] r);
      logic [KEY_WIDTH-1:0] t;
      t = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
      t[KEY_WIDTH-1 -: 4] = sbox(t[KEY_WIDTH-1 -: 4]);
      if (KEY_WIDTH == 128) t[KEY_WIDTH-5 -: 4] = sbox(t[KEY_WIDTH-5 -: 4]);
      t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ r;
      return t;
   endfunction

   // Inverse key schedule step: undo the counter, the S-box(es), then rotate right 61
   function automatic logic [KEY_WIDTH-1:0] key_inv(input logic [KEY_WIDTH-1:0] k,
                                                    input logic [4:0] r);
      logic [KEY_WIDTH-1:0] t;
      t = k;
      t[RC_LSB +: 5] = t[RC_LSB +: 5] ^ r;
      t[KEY_WIDTH-1 -: 4] = sbox_inv(t[KEY_WIDTH-1 -: 4]);
      if (KEY_WIDTH == 128) t[KEY_WIDTH-5 -: 4] = sbox_inv(t[KEY_WIDTH-5 -: 4]);
      return {t[60:0], t[KEY_WIDTH-1:61]};
   endfunction

   state_e               fsm_q, fsm_d;
   logic [63:0]          state_reg_q, state_reg_d;
   logic [KEY_WIDTH-1:0] key_reg_q, key_reg_d;
   logic [4:0]           round_q, round_d;
   logic                 mode_reg_q, mode_reg_d;

`ifdef PRESENT_KEY_CACHE_EN
   logic [KEY_WIDTH-1:0] cache_key_q, cache_key_d;
   logic [KEY_WIDTH-1:0] cache_sched_q, cache_sched_d;
   logic                 cache_valid_q, cache_valid_d;
`endif

   logic [63:0]          round_key;
   logic [KEY_WIDTH-1:0] key_fwd_w;
   logic [KEY_WIDTH-1:0] key_inv_w;

   assign round_key = key_reg_q[KEY_WIDTH-1 -: 64];
   assign key_fwd_w = key_fwd(key_reg_q, round_q);
   assign key_inv_w = key_inv(key_reg_q, round_q);

   // Next-state logic for the control FSM and the data/key datapath
   always_comb begin
      fsm_d       = fsm_q;
      state_reg_d = state_reg_q;
      key_reg_d   = key_reg_q;
      round_d     = round_q;
      mode_reg_d  = mode_reg_q;
`ifdef PRESENT_KEY_CACHE_EN
      cache_key_d   = cache_key_q;
      cache_sched_d = cache_sched_q;
      cache_valid_d = cache_valid_q;
`endif
      unique case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_reg_d = in_data;
               key_reg_d   = in_key;
               mode_reg_d  = mode;
               round_d     = 5'd1;
               if (!mode) begin
                  fsm_d = ROUND;
               end else begin
`ifdef PRESENT_KEY_CACHE_EN
                  if (cache_valid_q && (in_key == cache_key_q)) begin
                     key_reg_d = cache_sched_q;
                     round_d   = 5'd31;
                     fsm_d     = ROUND;
                  end else begin
                     cache_key_d   = in_key;
                     cache_valid_d = 1'b0;
                     fsm_d         = KEYGEN;
                  end
`else
                  fsm_d = KEYGEN;
`endif
               end
            end
         end
         KEYGEN: begin
            key_reg_d = key_fwd_w;
            if (round_q == 5'd31) begin
               round_d = 5'd31;
               fsm_d   = ROUND;
`ifdef PRESENT_KEY_CACHE_EN
               cache_sched_d = key_fwd_w;
               cache_valid_d = 1'b1;
`endif
            end else begin
               round_d = round_q + 5'd1;
            end
         end
         ROUND: begin
            if (!mode_reg_q) begin
               state_reg_d = p_layer(s_layer(state_reg_q ^ round_key));
               key_reg_d   = key_fwd_w;
               round_d     = round_q + 5'd1;
               if (round_q == 5'd31) fsm_d = DONE;
            end else begin
               state_reg_d = s_layer_inv(p_layer_inv(state_reg_q ^ round_key));
               key_reg_d   = key_inv_w;
               round_d     = round_q - 5'd1;
               if (round_q == 5'd1) fsm_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         fsm_q       <= IDLE;
         state_reg_q <= '0;
         key_reg_q   <= '0;
         round_q     <= '0;
         mode_reg_q  <= 1'b0;
`ifdef PRESENT_KEY_CACHE_EN
         cache_key_q   <= '0;
         cache_sched_q <= '0;
         cache_valid_q <= 1'b0;
`endif
      end else begin
         fsm_q       <= fsm_d;
         state_reg_q <= state_reg_d;
         key_reg_q   <= key_reg_d;
         round_q     <= round_d;
         mode_reg_q  <= mode_reg_d;
`ifdef PRESENT_KEY_CACHE_EN
         cache_key_q   <= cache_key_d;
         cache_sched_q <= cache_sched_d;
         cache_valid_q <= cache_valid_d;
`endif
      end
   end

   // Outputs decode registered state only; the final whitening key is the current top of key_reg
   always_comb begin
      in_ready  = (fsm_q == IDLE);
      out_valid = (fsm_q == DONE);
      busy      = (fsm_q != IDLE);
      round     = round_q;
      out_data  = (fsm_q == DONE) ? (state_reg_q ^ round_key) : 64'h0;
   end

endmodule

// File: tb/tb_present_cipher_core.sv
// tb_present_cipher_core: directed checks of the PRESENT core with 80-bit and 128-bit instances.
module tb_present_cipher_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_busy;
   logic [63:0] a_in_data, a_out_data;
   logic [79:0] a_in_key;
   logic [4:0]  a_round;

   logic         b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_busy;
   logic [63:0]  b_in_data, b_out_data;
   logic [127:0] b_in_key;
   logic [4:0]   b_round;

   int checks   = 0;
   int failures = 0;

`ifdef PRESENT_KEY_CACHE_EN
   localparam int CACHED_DEC_LAT = 31;
`else
   localparam int CACHED_DEC_LAT = 62;
`endif

   present_cipher_core #(.KEY_WIDTH(80)) dut80 (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
      .in_data(a_in_data), .in_key(a_in_key),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .busy(a_busy), .round(a_round)
   );

   present_cipher_core #(.KEY_WIDTH(128)) dut128 (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
      .in_data(b_in_data), .in_key(b_in_key),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .busy(b_busy), .round(b_round)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic get_out_valid(input bit wide);
      return wide ? b_out_valid : a_out_valid;
   endfunction

   function automatic logic get_in_ready(input bit wide);
      return wide ? b_in_ready : a_in_ready;
   endfunction

   function automatic logic [63:0] get_out_data(input bit wide);
      return wide ? b_out_data : a_out_data;
   endfunction

   // Issue one request, wait (bounded) for out_valid; returns at a negedge with the result held
   task automatic applyStimulus(input bit wide, input bit dec, input logic [127:0] key,
                                input logic [63:0] data, output logic [63:0] result,
                                output int latency, output bit ready_leak);
      @(negedge clk);
      if (wide) begin
         b_in_valid = 1'b1; b_mode = dec; b_in_key = key; b_in_data = data;
      end else begin
         a_in_valid = 1'b1; a_mode = dec; a_in_key = key[79:0]; a_in_data = data;
      end
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      ready_leak = get_in_ready(wide);
      latency = 0;
      while (latency < 200) begin
         @(posedge clk);
         latency++;
         @(negedge clk);
         if (get_out_valid(wide)) break;
         if (get_in_ready(wide)) ready_leak = 1'b1;
      end
      result = get_out_data(wide);
   endtask

   // Complete the output handshake and confirm the core is idle again
   task automatic releaseOutput(input bit wide, input string tag);
      if (wide) b_out_ready = 1'b1; else a_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      checkOutput({tag, "_idle_ready"}, 64'(get_in_ready(wide)), 64'd1);
   endtask

   initial begin
      logic [63:0]  res;
      logic [63:0]  ct;
      logic [127:0] rkey;
      logic [63:0]  rdata;
      int           lat;
      int           n;
      bit           leak;

      reset = 1'b0;
      a_in_valid = 1'b0; a_mode = 1'b0; a_in_data = '0; a_in_key = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_mode = 1'b0; b_in_data = '0; b_in_key = '0; b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_in_ready",  64'(a_in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(a_out_valid), 64'd0);
      checkOutput("rst_out_data",  a_out_data, 64'd0);
      checkOutput("rst_busy",      64'(a_busy), 64'd0);
      checkOutput("rst_round",     64'(a_round), 64'd0);
      checkOutput("rst128_out_data", b_out_data, 64'd0);
      reset = 1'b1;

      $display("[TB] 80-bit encrypt, zero key");
      applyStimulus(1'b0, 1'b0, 128'h0, 64'h0, res, lat, leak);
      checkOutput("enc0_data", res, 64'h5579c1387b228445);
      checkOutput("enc0_latency", 64'(lat), 64'd31);
      releaseOutput(1'b0, "enc0");

      $display("[TB] 80-bit decrypt, all-ones key");
      applyStimulus(1'b0, 1'b1, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'h3333dcd3213210d2,
                    res, lat, leak);
      checkOutput("dec1_data", res, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("dec1_latency", 64'(lat), 64'd62);
      releaseOutput(1'b0, "dec1");

      applyStimulus(1'b0, 1'b1, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'h3333dcd3213210d2,
                    res, lat, leak);
      checkOutput("dec2_data", res, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("dec2_latency", 64'(lat), 64'(CACHED_DEC_LAT));
      releaseOutput(1'b0, "dec2");

      $display("[TB] mode toggling");
      applyStimulus(1'b0, 1'b0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'h0, res, lat, leak);
      checkOutput("tog_enc_data", res, 64'he72c46c0f5945049);
      checkOutput("tog_enc_ready_low", 64'(leak), 64'd0);
      releaseOutput(1'b0, "tog_enc");
      applyStimulus(1'b0, 1'b1, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'he72c46c0f5945049,
                    res, lat, leak);
      checkOutput("tog_dec_data", res, 64'h0);
      checkOutput("tog_dec_ready_low", 64'(leak), 64'd0);
      checkOutput("tog_dec_latency", 64'(lat), 64'(CACHED_DEC_LAT));
      releaseOutput(1'b0, "tog_dec");

      $display("[TB] backpressure");
      applyStimulus(1'b0, 1'b0, 128'h0, 64'h0, res, lat, leak);
      checkOutput("bp_first_data", res, 64'h5579c1387b228445);
      for (int i = 0; i < 10; i++) begin
         a_in_valid = i[0];
         a_mode     = 1'b1;
         a_in_data  = {$urandom, $urandom};
         @(posedge clk);
         @(negedge clk);
         checkOutput("bp_out_data",  a_out_data, 64'h5579c1387b228445);
         checkOutput("bp_out_valid", 64'(a_out_valid), 64'd1);
         checkOutput("bp_in_ready",  64'(a_in_ready), 64'd0);
      end
      a_in_valid = 1'b1;
      a_mode     = 1'b0;
      a_in_data  = 64'hFFFFFFFFFFFFFFFF;
      a_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      a_out_ready = 1'b0;
      checkOutput("bp_no_same_cycle_accept", 64'(a_busy), 64'd0);
      checkOutput("bp_idle_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_stays_idle", 64'(a_busy), 64'd0);

      $display("[TB] 128-bit encrypt, zero key");
      applyStimulus(1'b1, 1'b0, 128'h0, 64'h0, res, lat, leak);
      checkOutput("enc128_data", res, 64'h96db702a2e6900af);
      checkOutput("enc128_latency", 64'(lat), 64'd31);
      releaseOutput(1'b1, "enc128");

      $display("[TB] reset mid-operation");
      @(negedge clk);
      a_in_valid = 1'b1; a_mode = 1'b0; a_in_key = '0; a_in_data = '0;
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      n = 0;
      while (a_round != 5'd15 && n < 100) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      checkOutput("mid_reached_round15", 64'(a_round), 64'd15);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid_busy",      64'(a_busy), 64'd0);
      checkOutput("mid_out_valid", 64'(a_out_valid), 64'd0);
      checkOutput("mid_round",     64'(a_round), 64'd0);
      checkOutput("mid_in_ready",  64'(a_in_ready), 64'd1);
      checkOutput("mid_out_data",  a_out_data, 64'd0);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 128'h0, 64'hFFFFFFFFFFFFFFFF, res, lat, leak);
      checkOutput("post_rst_enc_data", res, 64'ha112ffc72f68417b);
      checkOutput("post_rst_enc_latency", 64'(lat), 64'd31);
      releaseOutput(1'b0, "post_rst");

      $display("[TB] 128-bit random round trips");
      for (int i = 0; i < 100; i++) begin
         rkey  = {$urandom, $urandom, $urandom, $urandom};
         rdata = {$urandom, $urandom};
         applyStimulus(1'b1, 1'b0, rkey, rdata, ct, lat, leak);
         if (b_out_valid) b_out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         b_out_ready = 1'b0;
         applyStimulus(1'b1, 1'b1, rkey, ct, res, lat, leak);
         checkOutput("rt128", res, rdata);
         if (b_out_valid) b_out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         b_out_ready = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/present_cipher_core.md
# present_cipher_core

Parametrised PRESENT block-cipher engine performing both encryption and decryption on 64-bit blocks with an 80- or 128-bit key, one round per clock. It supersedes the decrypt-only core in the crypto datapath. It adds:
- run-time mode select;
- a key-width parameter;
- valid/ready handshakes on both sides;
- an on-chip forward key expansion, so decryption takes the raw master key.

## Interface
- KEY_WIDTH, 80, master key width; legal values 80 or 128 only.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  core can accept a request.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on acceptance.
- in_data  in  64  plaintext (encrypt) or ciphertext (decrypt).
- in_key  in  KEY_WIDTH  master key.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  64  ciphertext or plaintext.
- busy  out  1  high in any state other than IDLE.
- round  out  5  current round counter, for debug.

## Operation
- **States:** IDLE, KEYGEN, ROUND, DONE. Registers: state_reg[63:0], key_reg[KEY_WIDTH-1:0], round[4:0], mode_reg.
- **Round key:** K_r = key_reg[KEY_WIDTH-1 -: 64].
- **Forward key update F(k, r):**
  - Rotate left by 61.
  - Apply S to the top nibble. For 128-bit keys, also apply S to the next nibble.
  - XOR r[4:0] into bits [19:15] (80-bit key) or [66:62] (128-bit key).
- **Inverse key update:** F⁻¹ reverses those steps in the opposite order: XOR r, inverse S, rotate right by 61.
- **IDLE:**
  - in_ready = 1.
  - On in_valid: latch in_data, in_key and mode, and set round = 1.
  - Next state is ROUND if encrypting, KEYGEN if decrypting.
- **KEYGEN (decrypt only), 31 cycles:**
  - key_reg ← F(key_reg, round); round increments.
  - After round 31, key_reg = K32 round-key state. Then round ← 31 and go to ROUND.
- **ROUND, encrypt:**
  - state_reg ← P(S(state_reg ^ K_r)).
  - key_reg ← F(key_reg, round); round increments.
  - After round 31, go to DONE.
- **ROUND, decrypt:**
  - state_reg ← S⁻¹(P⁻¹(state_reg ^ K_top)).
  - key_reg ← F⁻¹(key_reg, round); round decrements.
  - After round 1, go to DONE.
- **DONE:**
  - out_valid = 1 and out_data = state_reg ^ K_top. Both modes use the same final whitening.
  - Output is held stable while out_ready = 0.
  - out_valid & out_ready moves the core to IDLE. The core cannot accept a new request in that same cycle.
- **Back-to-back and mid-operation requests:** in_valid is ignored outside IDLE. The caller must hold its request until in_ready.
- **Illegal KEY_WIDTH:** elaboration error.

## Timing
- **Reset values:**
  - Reset applies when reset = 0 at a clk edge.
  - All registers go to 0 and the state to IDLE.
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, busy = 0, round = 0.
- **Reset mid-operation:** aborts the operation in the same edge. No output is produced.
- **Encrypt latency:** acceptance at edge 0, so out_valid is high after edge 31.
- **Decrypt latency:** out_valid is high after edge 62 (31 KEYGEN + 31 ROUND).
- **Throughput:** one block per latency + 2 cycles when out_ready is tied high.
- **Timing paths:** out_data is combinational from registers only. There is no input-to-output combinational path, and in_ready depends on state only.

## Configuration
- **PRESENT_KEY_CACHE_EN defined:**
  - On the exit from KEYGEN, the core stores the master key and the resulting last-round key state, and sets a cache-valid flag. The flag is cleared by reset.
  - A decrypt request whose in_key equals the cached master key skips KEYGEN: it loads the cached last-round key and goes directly to ROUND with round = 31. Decrypt latency then equals encrypt latency (31).
  - An encrypt request does not disturb the cache.
- **PRESENT_KEY_CACHE_EN undefined:** no cache storage is built, and every decrypt runs KEYGEN.

## Test plan
- **Encrypt, zero key:** KEY_WIDTH=80, key 0, pt 0000000000000000 → out_data 5579c1387b228445, out_valid 31 edges after acceptance.
- **Decrypt, all-ones key:** KEY_WIDTH=80, key FFFFFFFFFFFFFFFFFFFF, ct 3333dcd3213210d2 → out_data FFFFFFFFFFFFFFFF after 62 edges. With PRESENT_KEY_CACHE_EN, a second identical request returns after 31 edges.
- **Mode toggling:** KEY_WIDTH=80, key all-ones, encrypt pt 0 → e72c46c0f5945049, then decrypt that value → 0. Check in_ready = 0 throughout both operations.
- **128-bit encrypt:** KEY_WIDTH=128, key 0, pt 0 → 96db702a2e6900af. Random round-trip of 100 key/data pairs returns the original data.
- **Backpressure:** hold out_ready = 0 for 10 cycles in DONE → out_data stable and in_ready = 0. Pulsing in_valid during that time is ignored.
- **Reset mid-operation:** drive reset = 0 at round 15 → next cycle state IDLE, out_valid = 0, round = 0, busy = 0. A following encrypt with key 0, pt FFFFFFFFFFFFFFFF → a112ffc72f68417b.
